ahb_lite_burst_master: RTL and testbench
========================================

// Module: ahb_lite_burst_master
// PURPOSE
//  Command-driven AHB-Lite master that feeds the shared AHB-Lite bus typedefs (ahb_trans_t/size/burst/prot).
//  Turns one {addr,size,burst,len} command into a legal NONSEQ/SEQ transfer sequence with INCR/WRAP address generation.
//  Also handles HREADY wait states, 1KB boundary and the two-cycle ERROR response. Sits between DMA/CPU-side logic and the bus.
// PARAMETERS
//  ADDR_WIDTH  32  HADDR width
//  DATA_WIDTH  32  HWDATA/HRDATA width; cmd_size_i must not exceed log2(DATA_WIDTH/8)
// PORTS
//  clk_i        in   1   clock (HCLK)
//  rst_n_i      in   1   async active-low reset (HRESETn)
//  cmd_valid_i  in   1   command valid
//  cmd_ready_o  out  1   high only in IDLE; command accepted on valid&ready
//  cmd_addr_i   in   ADDR_WIDTH start address, aligned to size
//  cmd_write_i  in   1   1=write, 0=read
//  cmd_size_i   in   3   ahb_size_t
//  cmd_burst_i  in   3   ahb_burst_t
//  cmd_len_i    in   8   beats-1, used only for AHB_BURST_INCR (1..256 beats)
//  cmd_prot_i   in   4   ahb_prot_t packed {prot_3..prot_0}
//  wr_data_i    in   DATA_WIDTH write data for beat whose address phase is accepted
//  wr_ready_o   out  1   pulse: wr_data_i consumed this cycle
//  rd_data_o    out  DATA_WIDTH read data, valid with rd_valid_o
//  rd_valid_o   out  1   pulse per completed read beat
//  done_o       out  1   1-cycle pulse at end of command
//  err_o        out  1   qualifies done_o: command terminated by HRESP=ERROR
//  haddr_o/htrans_o/hwrite_o/hsize_o/hburst_o/hprot_o/hwdata_o  out  AHB-Lite master address/data outputs
//  hrdata_i  in  DATA_WIDTH ; hready_i  in  1 ; hresp_i  in  1 (0=OKAY,1=ERROR)
// BEHAVIOUR
//  Reset: all outputs 0; htrans_o=AHB_TRANS_IDLE; cmd_ready_o=1 after reset release; FSM=IDLE.
//  FSM: IDLE -> ADDR on accept; ADDR/BURST advance only when hready_i=1; BURST -> LAST when final address phase accepted;
//   LAST -> IDLE on hready_i&!hresp_i (done_o=1); any data phase with hresp_i=1&!hready_i -> ERR.
//  Beats: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=cmd_len_i+1.
//  First beat NONSEQ, rest SEQ; haddr/hsize/hburst/hprot/hwrite held stable while hready_i=0.
//  Step = 1<<size. INCR*: addr+step. WRAP*: bound=beats*step; next = (addr & ~(bound-1)) | ((addr+step) & (bound-1)).
//  AHB_BURST_INCR crossing 1KB: beat at new 1KB page issued as NONSEQ, hburst_o stays INCR; fixed-length INCRn never cross (caller rule).
//  Pipelining: address phase of beat n+1 overlaps data phase of beat n; latency cmd accept -> first NONSEQ = 1 cycle.
//  Write: wr_ready_o=1 when a write address phase is accepted; hwdata_o registered then, held until that data phase completes.
//  Read: rd_valid_o=1, rd_data_o=hrdata_i captured on each read data phase with hready_i=1 & hresp_i=0.
//  ERROR: cycle 1 (hresp=1,hready=0) -> htrans_o forced IDLE next cycle, remaining beats dropped;
//   cycle 2 (hresp=1,hready=1) -> done_o=1, err_o=1, back to IDLE. Errored read beat gives no rd_valid_o.
//  cmd_valid_i outside IDLE ignored (cmd_ready_o=0). Reset mid-burst: outputs to reset values immediately (async).
// CONFIGURATION
//  AHB_LITE_MASTER_BUSY_EN defined: adds input wr_valid_i (1 bit). In a write burst, if wr_valid_i=0 when the
//   next SEQ beat is due, htrans_o=AHB_TRANS_BUSY with haddr_o = pending beat address. Resume SEQ when wr_valid_i=1.
//   First beat waits in IDLE trans until wr_valid_i=1. BUSY never used for last beat of fixed-length bursts.
//  Not defined: no wr_valid_i; write data assumed always available, BUSY never issued.
// TESTING
//  SINGLE write addr=0x100,size=32b,hready=1 -> one NONSEQ @0x100, wr_ready_o 1 pulse, done_o 2 cycles after NONSEQ.
//  INCR4 read 0x200 with hready=0 for 2 cycles on beat 2 -> addr 0x200,0x204,0x208,0x20C held stable, 4 rd_valid_o.
//  WRAP4 32b at 0x38 -> 0x38,0x3C,0x30,0x34; WRAP8 16b at 0x0E -> 0x0E,0x00,0x02..0x0C.
//  INCR len=3, 32b at 0x3F8 -> NONSEQ 0x3F8, SEQ 0x3FC, NONSEQ 0x400, SEQ 0x404.
//  INCR8 write, ERROR on beat 3 -> htrans_o IDLE next cycle, no beats 4-8, done_o&err_o together.
//  BUSY_EN: INCR4 write, wr_valid_i low 3 cycles before beat 2 -> 3 BUSY cycles at beat-2 address, then SEQ.

Source files
------------

// File: rtl/ahb_lite_burst_master.sv
// Command-driven AHB-Lite burst master: one {addr,size,burst,len} command becomes a pipelined NONSEQ/SEQ sequence.
// Optional BUSY insertion for stalled write data is enabled with `define AHB_LITE_MASTER_BUSY_EN.
module ahb_lite_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_write_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [2:0]            cmd_burst_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [3:0]            cmd_prot_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
`ifdef AHB_LITE_MASTER_BUSY_EN
  input  logic                  wr_valid_i,
`endif
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic [DATA_WIDTH-1:0] hrdata_i,
  input  logic                  hready_i,
  input  logic                  hresp_i
);

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam logic [2:0] AHB_BURST_SINGLE = 3'd0;
  localparam logic [2:0] AHB_BURST_INCR   = 3'd1;
  localparam logic [2:0] AHB_BURST_WRAP4  = 3'd2;
  localparam logic [2:0] AHB_BURST_INCR4  = 3'd3;
  localparam logic [2:0] AHB_BURST_WRAP8  = 3'd4;
  localparam logic [2:0] AHB_BURST_INCR8  = 3'd5;
  localparam logic [2:0] AHB_BURST_WRAP16 = 3'd6;
  localparam logic [2:0] AHB_BURST_INCR16 = 3'd7;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]            state;
  logic [7:0]            beats_left;
  logic                  dp_valid;

  logic                  addr_acc;
  logic                  busy_hold;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [1:0]            next_kind;
  logic [7:0]            cmd_beats_m1;
`ifdef AHB_LITE_MASTER_BUSY_EN
  logic [1:0]            cur_kind;
`endif

  // Next-beat address generation, beat count decode and write-stall decision.
  always_comb begin
    addr_acc = hready_i && htrans_o[1];
    step     = ADDR_WIDTH'(1'b1) << hsize_o;
    case (hburst_o)
      AHB_BURST_WRAP4:  wrap_mask = (step << 2) - ADDR_WIDTH'(1'b1);
      AHB_BURST_WRAP8:  wrap_mask = (step << 3) - ADDR_WIDTH'(1'b1);
      AHB_BURST_WRAP16: wrap_mask = (step << 4) - ADDR_WIDTH'(1'b1);
      default:          wrap_mask = '1;
    endcase
    // With an all-ones mask this reduces to a plain increment.
    next_addr = (haddr_o & ~wrap_mask) | ((haddr_o + step) & wrap_mask);
    if (hburst_o == AHB_BURST_INCR && next_addr[9:0] == 10'd0) begin
      next_kind = AHB_TRANS_NONSEQ;
    end else begin
      next_kind = AHB_TRANS_SEQ;
    end
    case (cmd_burst_i)
      AHB_BURST_SINGLE: cmd_beats_m1 = 8'd0;
      AHB_BURST_INCR:   cmd_beats_m1 = cmd_len_i;
      AHB_BURST_WRAP4,
      AHB_BURST_INCR4:  cmd_beats_m1 = 8'd3;
      AHB_BURST_WRAP8,
      AHB_BURST_INCR8:  cmd_beats_m1 = 8'd7;
      AHB_BURST_WRAP16,
      AHB_BURST_INCR16: cmd_beats_m1 = 8'd15;
      default:          cmd_beats_m1 = 8'd0;
    endcase
`ifdef AHB_LITE_MASTER_BUSY_EN
    busy_hold = hwrite_o && !wr_valid_i &&
                !(beats_left == 8'd1 && hburst_o != AHB_BURST_INCR);
    if (hburst_o == AHB_BURST_INCR && haddr_o[9:0] == 10'd0) begin
      cur_kind = AHB_TRANS_NONSEQ;
    end else begin
      cur_kind = AHB_TRANS_SEQ;
    end
`else
    busy_hold = 1'b0;
`endif
  end

  assign wr_ready_o = addr_acc && hwrite_o;

  // Command FSM, address-phase pipeline and data-phase completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      beats_left  <= 8'd0;
      dp_valid    <= 1'b0;
      cmd_ready_o <= 1'b0;
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      haddr_o     <= '0;
      htrans_o    <= AHB_TRANS_IDLE;
      hwrite_o    <= 1'b0;
      hsize_o     <= 3'd0;
      hburst_o    <= 3'd0;
      hprot_o     <= 4'd0;
      hwdata_o    <= '0;
    end else begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      if (wr_ready_o) begin
        hwdata_o <= wr_data_i;
      end
      case (state)
        S_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            haddr_o     <= cmd_addr_i;
            hwrite_o    <= cmd_write_i;
            hsize_o     <= cmd_size_i;
            hburst_o    <= cmd_burst_i;
            hprot_o     <= cmd_prot_i;
            beats_left  <= cmd_beats_m1;
            state       <= S_ADDR;
`ifdef AHB_LITE_MASTER_BUSY_EN
            htrans_o    <= (cmd_write_i && !wr_valid_i) ? AHB_TRANS_IDLE : AHB_TRANS_NONSEQ;
`else
            htrans_o    <= AHB_TRANS_NONSEQ;
`endif
          end
        end
        S_ADDR, S_BURST: begin
          if (dp_valid && hresp_i) begin
            // First ERROR cycle cancels the pending address phase.
            htrans_o <= AHB_TRANS_IDLE;
            if (hready_i) begin
              state       <= S_IDLE;
              cmd_ready_o <= 1'b1;
              dp_valid    <= 1'b0;
              done_o      <= 1'b1;
              err_o       <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end else if (hready_i) begin
            if (dp_valid && !hwrite_o) begin
              rd_valid_o <= 1'b1;
              rd_data_o  <= hrdata_i;
            end
            dp_valid <= addr_acc;
            if (addr_acc) begin
              if (beats_left == 8'd0) begin
                htrans_o <= AHB_TRANS_IDLE;
                state    <= S_LAST;
              end else begin
                haddr_o    <= next_addr;
                beats_left <= beats_left - 8'd1;
                htrans_o   <= busy_hold ? AHB_TRANS_BUSY : next_kind;
                state      <= S_BURST;
              end
            end
`ifdef AHB_LITE_MASTER_BUSY_EN
            else if (htrans_o == AHB_TRANS_BUSY) begin
              if (wr_valid_i) begin
                htrans_o <= cur_kind;
              end
            end else if (wr_valid_i) begin
              htrans_o <= AHB_TRANS_NONSEQ;
            end
`endif
          end
        end
        S_LAST: begin
          if (hresp_i) begin
            if (hready_i) begin
              state       <= S_IDLE;
              cmd_ready_o <= 1'b1;
              dp_valid    <= 1'b0;
              done_o      <= 1'b1;
              err_o       <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end else if (hready_i) begin
            if (!hwrite_o) begin
              rd_valid_o <= 1'b1;
              rd_data_o  <= hrdata_i;
            end
            state       <= S_IDLE;
            cmd_ready_o <= 1'b1;
            dp_valid    <= 1'b0;
            done_o      <= 1'b1;
          end
        end
        S_ERR: begin
          if (hready_i) begin
            state       <= S_IDLE;
            cmd_ready_o <= 1'b1;
            dp_valid    <= 1'b0;
            done_o      <= 1'b1;
            err_o       <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          htrans_o <= AHB_TRANS_IDLE;
          dp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Directed bench for ahb_lite_burst_master: single, stalled INCR4, WRAP4/WRAP8, 1KB-crossing INCR,
// ERROR termination and asynchronous reset mid-burst.
module tb_ahb_lite_burst_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'd0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_size = 3'd0;
  logic [2:0]  cmd_burst = 3'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic [3:0]  cmd_prot = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata = 32'd0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
`ifdef AHB_LITE_MASTER_BUSY_EN
  logic        wr_valid = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_a [8];
  logic [1:0]  exp_t [8];

  always #5 clk = ~clk;

  ahb_lite_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_write_i(cmd_write), .cmd_size_i(cmd_size), .cmd_burst_i(cmd_burst),
    .cmd_len_i(cmd_len), .cmd_prot_i(cmd_prot), .wr_data_i(wr_data),
`ifdef AHB_LITE_MASTER_BUSY_EN
    .wr_valid_i(wr_valid),
`endif
    .wr_ready_o(wr_ready), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .done_o(done), .err_o(err), .haddr_o(haddr), .htrans_o(htrans),
    .hwrite_o(hwrite), .hsize_o(hsize), .hburst_o(hburst), .hprot_o(hprot),
    .hwdata_o(hwdata), .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [2:0] bu, input logic [7:0] ln);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_size = sz;
    cmd_burst = bu; cmd_len = ln; cmd_prot = 4'h3;
  endtask

  // Read burst with zero wait states; address/trans expectations come from exp_a/exp_t.
  task automatic rd_burst(input string nm, input logic [31:0] a, input logic [2:0] sz,
                          input logic [2:0] bu, input logic [7:0] ln, input int n);
    adv();
    issue(a, 1'b0, sz, bu, ln);
    hready = 1'b1; hresp = 1'b0;
    smp();
    for (int i = 0; i < n + 2; i++) begin
      adv();
      cmd_valid = 1'b0;
      hrdata = 32'hD000_0000 + 32'(i);
      smp();
      if (i < n) begin
        chk({nm, "_haddr"}, haddr, exp_a[i]);
        chk({nm, "_htrans"}, {30'd0, htrans}, {30'd0, exp_t[i]});
        chk({nm, "_hburst"}, {29'd0, hburst}, {29'd0, bu});
      end else begin
        chk({nm, "_htrans_idle"}, {30'd0, htrans}, 32'd0);
      end
      if (i >= 2) begin
        chk({nm, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
        chk({nm, "_rd_data"}, rd_data, 32'hD000_0000 + 32'(i - 1));
      end
      chk({nm, "_done"}, {31'd0, done}, {31'd0, (i == n + 1)});
    end
  endtask

  initial begin
    // Reset state
    adv(); smp();
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    adv(); rst_n = 1'b1; smp();
    adv(); smp();
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // SINGLE write at 0x100
    adv(); issue(32'h100, 1'b1, 3'd2, 3'd0, 8'd0); wr_data = 32'hA5A5_0001; smp();
    chk("s_pre_htrans", {30'd0, htrans}, 32'd0);
    adv(); cmd_valid = 1'b0; smp();
    chk("s_htrans", {30'd0, htrans}, 32'd2);
    chk("s_haddr", haddr, 32'h100);
    chk("s_hwrite", {31'd0, hwrite}, 32'd1);
    chk("s_hsize", {29'd0, hsize}, 32'd2);
    chk("s_hprot", {28'd0, hprot}, 32'h3);
    chk("s_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("s_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    adv(); smp();
    chk("s_htrans2", {30'd0, htrans}, 32'd0);
    chk("s_hwdata", hwdata, 32'hA5A5_0001);
    chk("s_wr_ready2", {31'd0, wr_ready}, 32'd0);
    chk("s_done_early", {31'd0, done}, 32'd0);
    adv(); smp();
    chk("s_done", {31'd0, done}, 32'd1);
    chk("s_err", {31'd0, err}, 32'd0);

    // INCR4 read at 0x200, beat 2 data phase stalled two cycles; cmd_valid ignored mid-burst
    adv(); issue(32'h200, 1'b0, 3'd2, 3'd3, 8'd0); smp();
    adv(); cmd_addr = 32'h900; smp();
    chk("i4_a0", haddr, 32'h200);
    chk("i4_t0", {30'd0, htrans}, 32'd2);
    adv(); cmd_valid = 1'b0; hrdata = 32'h1111_0001; smp();
    chk("i4_a1", haddr, 32'h204);
    chk("i4_t1", {30'd0, htrans}, 32'd3);
    adv(); hready = 1'b0; hrdata = 32'h0; smp();
    chk("i4_rv1", {31'd0, rd_valid}, 32'd1);
    chk("i4_rd1", rd_data, 32'h1111_0001);
    chk("i4_a2", haddr, 32'h208);
    adv(); smp();
    chk("i4_a2_hold", haddr, 32'h208);
    chk("i4_t2_hold", {30'd0, htrans}, 32'd3);
    chk("i4_rv_stall", {31'd0, rd_valid}, 32'd0);
    adv(); hready = 1'b1; hrdata = 32'h2222_0002; smp();
    chk("i4_a2_hold2", haddr, 32'h208);
    adv(); hrdata = 32'h3333_0003; smp();
    chk("i4_rd2", rd_data, 32'h2222_0002);
    chk("i4_a3", haddr, 32'h20C);
    adv(); hrdata = 32'h4444_0004; smp();
    chk("i4_rd3", rd_data, 32'h3333_0003);
    chk("i4_t_idle", {30'd0, htrans}, 32'd0);
    adv(); smp();
    chk("i4_rv4", {31'd0, rd_valid}, 32'd1);
    chk("i4_rd4", rd_data, 32'h4444_0004);
    chk("i4_done", {31'd0, done}, 32'd1);

    // WRAP4 32-bit at 0x38
    exp_a = '{32'h38, 32'h3C, 32'h30, 32'h34, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_t = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    rd_burst("w4", 32'h38, 3'd2, 3'd2, 8'd0, 4);

    // WRAP8 16-bit at 0x0E
    exp_a = '{32'h0E, 32'h00, 32'h02, 32'h04, 32'h06, 32'h08, 32'h0A, 32'h0C};
    exp_t = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    rd_burst("w8", 32'h0E, 3'd1, 3'd4, 8'd0, 8);

    // INCR len=3 crossing the 1KB page at 0x400
    exp_a = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_t = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    rd_burst("incr1k", 32'h3F8, 3'd2, 3'd1, 8'd3, 4);

    // INCR8 write, ERROR response on beat 3
    adv(); issue(32'h1000, 1'b1, 3'd2, 3'd5, 8'd0); wr_data = 32'hC0DE_0000; smp();
    adv(); cmd_valid = 1'b0; smp();
    chk("e_a0", haddr, 32'h1000);
    chk("e_wr_ready0", {31'd0, wr_ready}, 32'd1);
    adv(); wr_data = 32'hC0DE_0001; smp();
    chk("e_a1", haddr, 32'h1004);
    chk("e_hwdata0", hwdata, 32'hC0DE_0000);
    adv(); wr_data = 32'hC0DE_0002; smp();
    chk("e_a2", haddr, 32'h1008);
    chk("e_hwdata1", hwdata, 32'hC0DE_0001);
    adv(); hready = 1'b0; hresp = 1'b1; wr_data = 32'hC0DE_0003; smp();
    chk("e_a3", haddr, 32'h100C);
    chk("e_hwdata2", hwdata, 32'hC0DE_0002);
    chk("e_wr_ready_err1", {31'd0, wr_ready}, 32'd0);
    adv(); hready = 1'b1; smp();
    chk("e_htrans_idle", {30'd0, htrans}, 32'd0);
    chk("e_done_early", {31'd0, done}, 32'd0);
    adv(); hresp = 1'b0; smp();
    chk("e_done", {31'd0, done}, 32'd1);
    chk("e_err", {31'd0, err}, 32'd1);
    chk("e_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    adv(); smp();
    chk("e_no_more_beats", {30'd0, htrans}, 32'd0);
    chk("e_done_clr", {31'd0, done}, 32'd0);

    // Asynchronous reset in the middle of a burst
    adv(); issue(32'h300, 1'b0, 3'd2, 3'd3, 8'd0); smp();
    adv(); cmd_valid = 1'b0; smp();
    chk("r_htrans_pre", {30'd0, htrans}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("r_htrans", {30'd0, htrans}, 32'd0);
    chk("r_haddr", haddr, 32'd0);
    chk("r_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    adv(); rst_n = 1'b1;
    adv(); smp();
    chk("r_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("r_htrans_idle", {30'd0, htrans}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
